vga_fb_arbiter: RTL and testbench

Sequences framebuffer scan-out for the 640x480 VGA pipeline and shares the single-port framebuffer memory with one writer (CPU/drawing engine). On each line request from the timing generator it burst-reads one active line (H_ACT words) into the line buffer that feeds the pixel datapath. Writer accesses are interleaved in idle slots, with a starvation guard. Runs entirely in the pixel clock domain.

---
 rtl/vga_fb_pkg.sv | 8 +
 rtl/vga_fb_arbiter.sv | 130 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared constants and state type for the framebuffer scan-out arbiter
package vga_fb_pkg;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int LW        = 10;

  typedef enum logic {IDLE, FETCH} fb_state_t;
endpackage

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - line-fetch sequencer sharing the framebuffer port with one writer
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DEF,
  parameter int V_ACT      = V_ACT_DEF,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 32
) (
  input  logic          clk_pix,
  input  logic          rst_n,
  input  logic          line_req,
  input  logic [LW-1:0] line_idx,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lb_we,
  output logic [LW-1:0] lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          err_overrun
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  fb_state_t     state, state_nx;
  logic [AW-1:0] base, base_nx, rd_addr, req_base;
  logic [LW-1:0] x, x_nx, rd_x, rd_x_q;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic          issue_rd, issue_wr, ovr, idx_ok;
  logic          rd_vld, rd_last;

  assign idx_ok   = (line_idx < LW'(V_ACT));
  assign req_base = AW'(line_idx) * AW'(H_ACT);

  always_comb begin
    state_nx  = state;
    base_nx   = base;
    x_nx      = x;
    starve_nx = starve_cnt;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    ovr       = 1'b0;
    rd_addr   = base + AW'(x);
    rd_x      = x;
    case (state)
      IDLE: begin
        starve_nx = '0;
        issue_wr  = wr_req;
        if (line_req && idx_ok) begin
          base_nx  = req_base;
          x_nx     = '0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        ovr = line_req;
        if (line_req && idx_ok) begin
          // Restart immediately: the new line's x=0 read goes out in this cycle.
          base_nx   = req_base;
          rd_addr   = req_base;
          rd_x      = '0;
          x_nx      = LW'(1);
          issue_rd  = 1'b1;
          starve_nx = wr_req ? SW'(1) : '0;
        end else if (wr_req && starve_cnt == SW'(STARVE_MAX)) begin
          issue_wr  = 1'b1;
          starve_nx = '0;
        end else begin
          issue_rd  = 1'b1;
          x_nx      = x + LW'(1);
          starve_nx = wr_req ? starve_cnt + SW'(1) : '0;
          if (x == LW'(H_ACT - 1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      x           <= '0;
      starve_cnt  <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      wr_ack      <= 1'b0;
      fetch_busy  <= 1'b0;
      err_overrun <= 1'b0;
      rd_vld      <= 1'b0;
      rd_x_q      <= '0;
      rd_last     <= 1'b0;
      lb_we       <= 1'b0;
      lb_addr     <= '0;
      fetch_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      base        <= base_nx;
      x           <= x_nx;
      starve_cnt  <= starve_nx;
      mem_we      <= issue_wr;
      wr_ack      <= issue_wr;
      if (issue_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (issue_rd) begin
        mem_addr  <= rd_addr;
      end
      fetch_busy  <= (state == FETCH);
      err_overrun <= ovr;
      rd_vld      <= issue_rd;
      rd_x_q      <= rd_x;
      rd_last     <= issue_rd && (rd_x == LW'(H_ACT - 1));
      // Return stage: memory data lands one cycle after the issue registers.
      lb_we       <= rd_vld;
      lb_addr     <= rd_x_q;
      fetch_done  <= rd_vld && rd_last;
    end
  end

  assign lb_wdata = lb_we ? mem_rdata : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk_pix = 1'b0, rst_n = 1'b0, line_req = 1'b0, wr_req = 1'b0;
  logic [9:0]    line_idx = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, mem_we, lb_we, fetch_busy, fetch_done, err_overrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, lb_wdata;
  logic [9:0]    lb_addr;

  always #5 clk_pix = ~clk_pix;

  vga_fb_arbiter dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .line_req(line_req), .line_idx(line_idx),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .err_overrun(err_overrun)
  );

  logic [DW-1:0] fb [0:(1<<AW)-1];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
  endfunction

  always @(posedge clk_pix) begin
    if (mem_we) fb[mem_addr] <= mem_wdata;
    mem_rdata <= fb[mem_addr];
  end

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct packed {logic [9:0] x; logic [DW-1:0] d; logic last;} lb_t;

  logic [AW-1:0] rd_q[$];
  wr_t           wr_q[$];
  lb_t           lb_q[$];
  int            ack_cyc[$];
  int            done_cyc[$];
  int checks = 0, failures = 0, cyc = 0;
  int ovr_cnt = 0, lb_cnt = 0, busy_cnt = 0;
  wr_t           mw;
  lb_t           ml;
  logic [AW-1:0] ma;

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_pix) begin
    if (rst_n) begin
      if (fetch_busy) busy_cnt++;
      if (err_overrun) ovr_cnt++;
      if (wr_ack) ack_cyc.push_back(cyc);
      if (fetch_done) done_cyc.push_back(cyc);
      if (mem_we || wr_ack) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mw = wr_q.pop_front();
          chk("wr_addr", mem_addr, mw.a);
          chk("wr_data", mem_wdata, mw.d);
          chk("wr_ack_with_we", {wr_ack, mem_we}, 2'b11);
        end
      end
      if (fetch_busy && !mem_we) begin
        if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          ma = rd_q.pop_front();
          chk("rd_addr", mem_addr, ma);
        end
      end
      if (lb_we) begin
        lb_cnt++;
        if (lb_q.size() == 0) chk("unexpected_lb_we", 1, 0);
        else begin
          ml = lb_q.pop_front();
          chk("lb_addr", lb_addr, ml.x);
          chk("lb_wdata", lb_wdata, ml.d);
          chk("fetch_done", fetch_done, ml.last);
        end
      end else if (fetch_done) begin
        chk("done_without_lb", 1, 0);
      end
    end
  end

  task automatic push_line(input int idx, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'(idx * 640 + i);
      rd_q.push_back(a);
      lb_q.push_back({10'(i), pat(a), (i == 639)});
    end
  endtask

  task automatic issue_line(input int idx, output int t0);
    line_idx = 10'(idx);
    line_req = 1'b1;
    @(posedge clk_pix); #1;
    t0 = cyc;
    line_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((lb_q.size() != 0 || fetch_busy) && k < 3000) begin
      @(posedge clk_pix); #1;
      k++;
    end
    chk(name, (k < 3000), 1);
    repeat (3) @(posedge clk_pix);
    #1;
  endtask

  task automatic writer(input int n, input logic [AW-1:0] a0, input logic [DW-1:0] d0);
    int k;
    for (int i = 0; i < n; i++) begin
      wr_addr = a0 + AW'(i);
      wr_data = d0 + DW'(i);
      wr_req  = 1'b1;
      wr_q.push_back({a0 + AW'(i), d0 + DW'(i)});
      k = 0;
      do begin
        @(posedge clk_pix); #1;
        k++;
      end while (!wr_ack && k < 2000);
      if (!wr_ack) chk("writer_timeout", 0, 1);
    end
    wr_req = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_wr_ack"}, wr_ack, 0);
    chk({tag, "_lb_we"}, lb_we, 0);
    chk({tag, "_lb_addr"}, lb_addr, 0);
    chk({tag, "_lb_wdata"}, lb_wdata, 0);
    chk({tag, "_fetch_busy"}, fetch_busy, 0);
    chk({tag, "_fetch_done"}, fetch_done, 0);
    chk({tag, "_err_overrun"}, err_overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, bc, lc, oc, dc, bad;
    for (int i = 0; i < (1 << AW); i++) fb[i] = pat(AW'(i));
    repeat (3) @(posedge clk_pix);
    #1;
    reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk_pix);
    #1;

    // Line 0, uncontended: 640 back-to-back reads, done 641 cycles after the request edge.
    dc = done_cyc.size();
    bc = busy_cnt;
    push_line(0, 640);
    issue_line(0, t0);
    wait_idle("line0_idle");
    chk("line0_busy_cycles", busy_cnt - bc, 640);
    chk("line0_done_count", done_cyc.size() - dc, 1);
    if (done_cyc.size() > dc) chk("line0_done_latency", done_cyc[dc] - t0, 641);

    // Last valid line, then an out-of-range index that must be ignored.
    push_line(479, 640);
    issue_line(479, t0);
    wait_idle("line479_idle");
    bc = busy_cnt;
    lc = lb_cnt;
    oc = ovr_cnt;
    issue_line(480, t0);
    repeat (20) @(posedge clk_pix);
    #1;
    chk("line480_busy", busy_cnt - bc, 0);
    chk("line480_lb", lb_cnt - lc, 0);
    chk("line480_ovr", ovr_cnt - oc, 0);

    // Continuous writer during line 1: forced slot every 33 cycles, 660-cycle line.
    push_line(1, 640);
    ack_cyc.delete();
    dc = done_cyc.size();
    issue_line(1, t0);
    fork
      writer(20, 19'h70000, 8'h40);
    join_none
    wait_idle("starve_idle");
    repeat (5) @(posedge clk_pix);
    #1;
    chk("starve_ack_count", ack_cyc.size(), 20);
    if (ack_cyc.size() == 20) begin
      chk("starve_first_ack", ack_cyc[0] - t0, 33);
      bad = 0;
      for (int i = 1; i < 19; i++) if (ack_cyc[i] - ack_cyc[i-1] != 33) bad++;
      chk("starve_ack_spacing_bad", bad, 0);
      chk("starve_last_ack", ack_cyc[19] - t0, 660);
    end
    if (done_cyc.size() > dc) chk("starve_line_cycles", done_cyc[dc] - t0, 660);
    else chk("starve_done_seen", 0, 1);
    chk("starve_mem_last", fb[19'h70013], 8'h53);

    // Writer alone in IDLE.
    wr_addr = 19'h12345;
    wr_data = 8'hA5;
    wr_req  = 1'b1;
    wr_q.push_back({19'h12345, 8'hA5});
    @(posedge clk_pix); #1;
    chk("idle_wr_we", mem_we, 1);
    chk("idle_wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    @(posedge clk_pix); #1;
    chk("idle_wr_mem", fb[19'h12345], 8'hA5);
    chk("idle_wr_single", mem_we, 0);

    // Overrun: line 6 requested right after x=100 of line 5 has been issued.
    oc = ovr_cnt;
    dc = done_cyc.size();
    push_line(5, 101);
    issue_line(5, t0);
    bad = 0;
    while (!(fetch_busy && !mem_we && mem_addr == 19'd3300) && bad < 200) begin
      @(posedge clk_pix); #1;
      bad++;
    end
    chk("ovr_reach_x100", (bad < 200), 1);
    push_line(6, 640);
    issue_line(6, t0);
    wait_idle("ovr_idle");
    chk("ovr_pulses", ovr_cnt - oc, 1);
    chk("ovr_done_count", done_cyc.size() - dc, 1);

    // Asynchronous reset mid-fetch.
    push_line(2, 640);
    issue_line(2, t0);
    repeat (50) @(posedge clk_pix);
    #3;
    rst_n = 1'b0;
    #1;
    reset_outputs("midrst");
    rd_q.delete();
    lb_q.delete();
    @(posedge clk_pix); #1;
    rst_n = 1'b1;
    lc = lb_cnt;
    bc = busy_cnt;
    repeat (20) @(posedge clk_pix);
    #1;
    chk("post_rst_lb", lb_cnt - lc, 0);
    chk("post_rst_busy", busy_cnt - bc, 0);

    chk("end_rd_q", rd_q.size(), 0);
    chk("end_lb_q", lb_q.size(), 0);
    chk("end_wr_q", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
